// File: rtl/cla_multiword_adder.sv
// Sequential WORDS*16-bit adder: one 16-bit carry-lookahead slice is reused
// once per cycle, least-significant word first, with the slice carry registered.
module cla_multiword_adder #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WORDS*16-1:0] a,
    input  logic [WORDS*16-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [WORDS*16-1:0] sum,
    output logic                cout,
    output logic                ovf
);
    localparam int N  = WORDS * 16;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     a_sl, b_sl, s_sl;
    logic            c16;

    // Four-bit lookahead: returns carries into bits 1..4 from generate/propagate.
    function automatic logic [3:0] la4(input logic [3:0] gi, input logic [3:0] pi, input logic ci);
        logic [3:0] c;
        c[0] = gi[0] | (pi[0] & ci);
        c[1] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
        c[2] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
        c[3] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0])
             | (pi[3] & pi[2] & pi[1] & pi[0] & ci);
        return c;
    endfunction

    // CLA16bit: two-level lookahead over four nibble groups; returns {c16, s}.
    function automatic logic [16:0] cla16bit(input logic [15:0] x, input logic [15:0] y, input logic c0);
        logic [15:0] g, p, s;
        logic [3:0]  gg, pp, gc, cn, t;
        g = x & y;
        p = x ^ y;
        for (int unsigned n = 0; n < 4; n++) begin
            t     = la4(g[4*n +: 4], p[4*n +: 4], 1'b0);
            gg[n] = t[3];
            pp[n] = &p[4*n +: 4];
        end
        gc = la4(gg, pp, c0);
        cn = {gc[2:0], c0};
        for (int unsigned n = 0; n < 4; n++) begin
            t            = la4(g[4*n +: 4], p[4*n +: 4], cn[n]);
            s[4*n +: 4]  = p[4*n +: 4] ^ {t[2:0], cn[n]};
        end
        return {gc[3], s};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == IW'(w)) begin
                a_sl = a_q[16*w +: 16];
                b_sl = b_q[16*w +: 16];
            end
        end
        {c16, s_sl} = cla16bit(a_sl, b_sl, carry_q);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                end
            end
            RUN: begin
                for (int unsigned w = 0; w < WORDS; w++) begin
                    if (idx_q == IW'(w)) sum_d[16*w +: 16] = s_sl;
                end
                carry_d = c16;
                if (idx_q == LAST) begin
                    cout_d = c16;
                    // s_sl[15] is the final sum MSB, not yet visible in sum_q
                    ovf_d  = (a_q[N-1] == b_q[N-1]) && (s_sl[15] != a_q[N-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_cla_multiword_adder.sv
// Scoreboarded bench for cla_multiword_adder: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is seen.
module tb_cla_multiword_adder;
    localparam int WORDS = 4;
    localparam int N     = WORDS * 16;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [N-1:0] a, b;
    logic         busy, done, cout, ovf;
    logic [N-1:0] sum;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        int unsigned  cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        last_e;
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    cla_multiword_adder #(.WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [N:0] act, input logic [N:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got event expected none/other", name);
    endtask

    // Reference: plain (N+1)-bit unsigned and signed arithmetic.
    function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        exp_t        e;
        logic [N:0]  u;
        logic signed [N:0] sv;
        u      = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
        sv     = $signed({x[N-1], x}) + $signed({y[N-1], y}) + $signed({{N{1'b0}}, c});
        e.sum  = u[N-1:0];
        e.cout = u[N];
        e.ovf  = (sv > $signed({2'b00, {(N-1){1'b1}}})) || (sv < $signed({2'b11, {(N-1){1'b0}}}));
        e.cyc  = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            chk("busy_with_done", {{N{1'b0}}, busy}, '0);
            if (q.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                mon_e = q.pop_front();
                chk("sum",     {1'b0, sum}, {1'b0, mon_e.sum});
                chk("cout",    (N+1)'(cout), (N+1)'(mon_e.cout));
                chk("ovf",     (N+1)'(ovf),  (N+1)'(mon_e.ovf));
                chk("latency", (N+1)'(cyc),  (N+1)'(mon_e.cyc));
            end
        end
    end

    task automatic do_add(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc, input bit disturb);
        exp_t        e;
        int unsigned k;
        e = model(ta, tb, tc);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; cin = tc;
        e.cyc  = cyc + 1 + WORDS;
        last_e = e;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            a = ~ta; b = {$urandom, $urandom}; cin = ~tc;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (q.size() != 0 && k < WORDS + 8) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            fail_now("done_timeout");
            q.delete();
        end
        @(negedge clk);
        @(negedge clk);
        chk("hold_sum",  {1'b0, sum}, {1'b0, last_e.sum});
        chk("hold_cout", (N+1)'(cout), (N+1)'(last_e.cout));
        chk("hold_ovf",  (N+1)'(ovf),  (N+1)'(last_e.ovf));
        chk("idle_busy", (N+1)'(busy), '0);
    endtask

    function automatic logic [N-1:0] rnd_word();
        logic [N-1:0] r;
        for (int i = 0; i < N / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", (N+1)'(busy), '0);
        chk("rst_done", (N+1)'(done), '0);
        chk("rst_sum",  {1'b0, sum}, '0);
        chk("rst_cout", (N+1)'(cout), '0);
        chk("rst_ovf",  (N+1)'(ovf), '0);
        rst = 1'b0;

        do_add(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        do_add(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        do_add(64'h0, 64'h0, 1'b1, 1'b0);
        do_add(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0);
        do_add(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
        do_add(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b1);

        // Abort mid-RUN: no done may follow, outputs return to zero.
        @(negedge clk);
        start = 1'b1; a = 64'hFFFF; b = 64'h1; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("run_busy", (N+1)'(busy), (N+1)'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", (N+1)'(busy), '0);
        chk("abort_done", (N+1)'(done), '0);
        chk("abort_sum",  {1'b0, sum}, '0);
        chk("abort_cout", (N+1)'(cout), '0);
        chk("abort_ovf",  (N+1)'(ovf), '0);
        repeat (WORDS + 3) @(negedge clk);
        do_add(64'd3, 64'd4, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ra = rnd_word();
            rb = rnd_word();
            if (i % 5 == 0) rb = ~ra;
            if (i % 7 == 0) ra[N-1] = rb[N-1];
            do_add(ra, rb, 1'($urandom), bit'(i % 4 == 0));
        end

        repeat (WORDS + 3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
